// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Holds the opcode and funct constants, the 3-bit ALU control words, the
// 2-bit aluop codes passed to the ALU decoder, and the 4-bit FSM state
// encodings.
package mips_pkg;

  // Opcodes taken from instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field values taken from instr[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control words
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop codes from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // FSM state encodings; 12..15 are unused and recover to FETCH
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder.
// Ports:
//   aluop         in  2  operation class requested by the FSM
//   funct         in  6  instr[5:0], used only when aluop selects funct
//   alucontrol    out 3  ALU control word
//   funct_illegal out 1  funct not supported while aluop selects funct
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default: begin
            // Unsupported funct: harmless add, flagged so the write is dropped
            alucontrol    = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath.
// Sequences each instruction over 3-5 cycles (longer when mem_ready stalls
// FETCH, MEMRD or MEMWR) and drives datapath mux selects, write enables and
// the ALU control word.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op, funct           instruction fields from the instruction register
//   zero                ALU zero flag, used for beq
//   mem_ready           memory completes the current access this cycle
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, pcsrc      datapath controls (Moore, from state)
//   pcen                PC load enable = pcwrite | (branch & zero)
//   alucontrol          3-bit ALU control word
//   illegal             1-cycle pulse on unsupported opcode or funct
module mips_multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [1:0] aluop;
  logic       funct_illegal;
  logic       funct_bad;
  logic       op_illegal;
  logic       pcwrite;
  logic       branch;
  logic       irwrite_raw;
  logic       memwrite_raw;
  logic       regwrite_raw;
  logic       illegal_raw;

  mips_alu_decoder u_alu_decoder (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  // State register; funct_bad remembers an unsupported funct seen in
  // RTYPEEX so the following RTYPEWB suppresses its register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      funct_bad <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_RTYPEEX) begin
        funct_bad <= funct_illegal;
      end
    end
  end

  always_comb begin
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
      default:                                       op_illegal = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = ALUOP_ADD;
    illegal_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
      end
      S_DECODE: begin
        alusrcb     = 2'b11;
        illegal_raw = op_illegal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_FUNCT;
        illegal_raw = funct_illegal;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = !funct_bad;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables and illegal are gated by rst_n so they drop the instant
  // reset asserts, independent of the clock.
  assign irwrite  = irwrite_raw & rst_n;
  assign memwrite = memwrite_raw & rst_n;
  assign regwrite = regwrite_raw & rst_n;
  assign illegal  = illegal_raw & rst_n;
  assign pcen     = (pcwrite | (branch & zero)) & rst_n;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed testbench for mips_multicycle_controller. Outputs are packed
// into one 16-bit word and compared per cycle against hand-built vectors.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [15:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  mips_multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca}, alusrcb,
  // pcsrc, pcen, alucontrol, illegal
  assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal};

  localparam logic [15:0] E_FETCH       = {7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
  localparam logic [15:0] E_FETCH_IDLE  = {7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_DECODE      = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_DECODE_ILL  = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b1};
  localparam logic [15:0] E_MEMADR      = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMRD       = {7'b1000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMWB       = {7'b0000110, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMWR       = {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_RWB         = {7'b0001010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_RWB_SUP     = {7'b0001000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_BEQ_TAKEN   = {7'b0000001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
  localparam logic [15:0] E_BEQ_NOT     = {7'b0000001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
  localparam logic [15:0] E_ADDIEX      = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_ADDIWB      = {7'b0000010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_JEX         = {7'b0000000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    op        = 6'b000000;
    funct     = 6'b100000;
    zero      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({pcen, irwrite, memwrite, regwrite, illegal} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_enables cyc%0d got=%b want=00000", i,
                 {pcen, irwrite, memwrite, regwrite, illegal});
      end
      n_cmp++;
      if (obs !== E_FETCH_IDLE) begin
        n_fail++;
        $display("FAIL reset_selects cyc%0d got=%h want=%h", i, obs, E_FETCH_IDLE);
      end
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs !== E_FETCH) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", obs, E_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [15:0] e [5];
    e = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL lw cyc%0d got=%h want=%h", i + 1, obs, e[i]);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6];
    logic [2:0] ctl [6];
    logic       ill [6];
    logic [15:0] e [4];
    fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    ctl = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
    ill = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1};
    for (int k = 0; k < 6; k++) begin
      op    = 6'b000000;
      funct = fn[k];
      e[0] = E_FETCH;
      e[1] = E_DECODE;
      e[2] = {7'b0000001, 2'b00, 2'b00, 1'b0, ctl[k], ill[k]};
      e[3] = ill[k] ? E_RWB_SUP : E_RWB;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_cmp++;
        if (obs !== e[i]) begin
          n_fail++;
          $display("FAIL rtype_f%b cyc%0d got=%h want=%h", fn[k], i + 1, obs, e[i]);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_addi();
    logic [15:0] e [4];
    e = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB};
    op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL addi cyc%0d got=%h want=%h", i + 1, obs, e[i]);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [3];
    logic        zs  [3];
    logic [15:0] ex  [3];
    logic [15:0] e   [3];
    ops = '{6'b000100, 6'b000100, 6'b000010};
    zs  = '{1'b1,      1'b0,      1'b0};
    ex  = '{E_BEQ_TAKEN, E_BEQ_NOT, E_JEX};
    for (int k = 0; k < 3; k++) begin
      op   = ops[k];
      zero = zs[k];
      e = '{E_FETCH, E_DECODE, ex[k]};
      for (int i = 0; i < 3; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_cmp++;
        if (obs !== e[i]) begin
          n_fail++;
          $display("FAIL brj%0d cyc%0d got=%h want=%h", k, i + 1, obs, e[i]);
        end
      end
      @(negedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_mem_stall();
    logic [15:0] e [3];
    int nwr;
    e = '{E_FETCH, E_DECODE, E_MEMADR};
    op = 6'b101011;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (obs !== e[i]) begin
        n_fail++;
        $display("FAIL sw_stall cyc%0d got=%h want=%h", i + 1, obs, e[i]);
      end
    end
    mem_ready = 1'b0;
    nwr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (memwrite === 1'b1) nwr++;
      n_cmp++;
      if (obs !== E_MEMWR) begin
        n_fail++;
        $display("FAIL sw_memwr wait%0d got=%h want=%h", i, obs, E_MEMWR);
      end
    end
    n_cmp++;
    if (nwr !== 4) begin
      n_fail++;
      $display("FAIL sw_memwrite_count got=%0d want=4", nwr);
    end
    // Now back in FETCH; stall it for two cycles
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (obs !== E_FETCH_IDLE) begin
        n_fail++;
        $display("FAIL fetch_stall cyc%0d got=%h want=%h", i, obs, E_FETCH_IDLE);
      end
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs !== E_FETCH) begin
      n_fail++;
      $display("FAIL fetch_ready got=%h want=%h", obs, E_FETCH);
    end
  endtask

  task automatic test_illegal_and_abort();
    op = 6'b111111;
    n_cmp++;
    if (obs !== E_FETCH) begin
      n_fail++;
      $display("FAIL illop_fetch got=%h want=%h", obs, E_FETCH);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== E_DECODE_ILL) begin
      n_fail++;
      $display("FAIL illop_decode got=%h want=%h", obs, E_DECODE_ILL);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== E_FETCH) begin
      n_fail++;
      $display("FAIL illop_return got=%h want=%h", obs, E_FETCH);
    end
    // sw stuck in MEMWR, then reset mid-access
    op = 6'b101011;
    repeat (2) begin @(negedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== E_MEMWR) begin
      n_fail++;
      $display("FAIL abort_memwr got=%h want=%h", obs, E_MEMWR);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (memwrite !== 1'b0 || obs !== E_FETCH_IDLE) begin
      n_fail++;
      $display("FAIL abort_reset got=%h want=%h", obs, E_FETCH_IDLE);
    end
    mem_ready = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs !== E_FETCH) begin
      n_fail++;
      $display("FAIL abort_release got=%h want=%h", obs, E_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_addi();
    test_branch_jump();
    test_mem_stall();
    test_illegal_and_abort();
    test_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
